sync_handshake_rx: RTL and testbench

Receiving end of the four-phase req/ack clock-domain-crossing handshake. It runs entirely in the destination (OCLK) domain and consumes the already-synchronized request and the quasi-static data bus held by the sending side. It waits a configurable settle time, captures the bus, and presents it to a local consumer with valid/ready. It returns the acknowledge and then completes the return-to-zero phase. It also flags protocol violations and counts completed transfers.

---
 rtl/sync_handshake_pkg.sv | 18 +
 rtl/sync_handshake_rx.sv | 134 +++++++++++++
 tb/tb_sync_handshake_rx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_handshake_pkg.sv
// Shared types and helpers for the four-phase req/ack handshake receiver.
package sync_handshake_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2,
        ACK    = 2'd3
    } sync_hs_rx_state_e;

    // Width of the settle counter: enough to hold settle_cyc, never below 1 bit.
    function automatic int unsigned settle_cnt_w(input int unsigned settle_cyc);
        int unsigned w;
        w = $clog2(settle_cyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_handshake_rx.sv
// Destination-side half of a four-phase req/ack CDC handshake. Waits for the
// quasi-static bus to settle, captures it, offers it to a local consumer with
// valid/ready, then acknowledges and completes the return-to-zero phase.
// Protocol violations (request withdrawn before ack) raise a sticky error.
module sync_handshake_rx
    import sync_handshake_pkg::*;
#(
    parameter int unsigned P_D_BITWIDTH   = 32,
    parameter int unsigned P_SETTLE_CYC   = 2,
    parameter int unsigned P_CNT_BITWIDTH = 16
) (
    input  logic                      OCLK,
    input  logic                      RST_OCLK,
    input  logic                      REQ_OCLK,
    input  logic [P_D_BITWIDTH-1:0]   D_IN_OCLK,
    output logic                      ACK_OCLK,
    output logic [P_D_BITWIDTH-1:0]   D_OUT_OCLK,
    output logic                      VALID_OCLK,
    input  logic                      RDY_OCLK,
    output logic                      ERR_OCLK,
    output logic [P_CNT_BITWIDTH-1:0] XFER_CNT_OCLK
);

    localparam int unsigned SETTLE_W = settle_cnt_w(P_SETTLE_CYC);
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(P_SETTLE_CYC);

    sync_hs_rx_state_e   state_q;
    sync_hs_rx_state_e   state_d;
    logic [SETTLE_W-1:0] settle_cnt_q;
    logic                ack_d;
    logic                valid_d;
    logic                err_d;
    logic                settle_load;
    logic                settle_dec;
    logic                capture;
    logic                xfer_inc;

    // Next-state and registered-output decode; request withdrawal wins over ready.
    always_comb begin
        state_d     = state_q;
        ack_d       = ACK_OCLK;
        valid_d     = VALID_OCLK;
        err_d       = ERR_OCLK;
        settle_load = 1'b0;
        settle_dec  = 1'b0;
        capture     = 1'b0;
        xfer_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ_OCLK) begin
                    settle_load = 1'b1;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                if (!REQ_OCLK) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (settle_cnt_q != '0) begin
                    settle_dec = 1'b1;
                end else begin
                    capture = 1'b1;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!REQ_OCLK) begin
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (RDY_OCLK) begin
                    valid_d  = 1'b0;
                    ack_d    = 1'b1;
                    xfer_inc = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                // Only the falling request matters here; a new word waits for IDLE.
                if (!REQ_OCLK) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state plus the handshake/status flags it owns.
    always_ff @(posedge OCLK) begin
        if (RST_OCLK) begin
            state_q    <= IDLE;
            ACK_OCLK   <= 1'b0;
            VALID_OCLK <= 1'b0;
            ERR_OCLK   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ACK_OCLK   <= ack_d;
            VALID_OCLK <= valid_d;
            ERR_OCLK   <= err_d;
        end
    end

    // Settle counter: loaded on request detection, counts down to the capture point.
    always_ff @(posedge OCLK) begin
        if (RST_OCLK) begin
            settle_cnt_q <= '0;
        end else if (settle_load) begin
            settle_cnt_q <= SETTLE_INIT;
        end else if (settle_dec) begin
            settle_cnt_q <= settle_cnt_q - 1'b1;
        end
    end

    // Capture register: the only place D_OUT_OCLK changes, so it is stable while valid.
    always_ff @(posedge OCLK) begin
        if (RST_OCLK) begin
            D_OUT_OCLK <= '0;
        end else if (capture) begin
            D_OUT_OCLK <= D_IN_OCLK;
        end
    end

    // Completed-transfer counter, wraps naturally at its width.
    always_ff @(posedge OCLK) begin
        if (RST_OCLK) begin
            XFER_CNT_OCLK <= '0;
        end else if (xfer_inc) begin
            XFER_CNT_OCLK <= XFER_CNT_OCLK + 1'b1;
        end
    end

endmodule

// File: tb/tb_sync_handshake_rx.sv
// Self-checking bench for sync_handshake_rx: timing of the handshake phases,
// backpressure, protocol errors, reset mid-transfer and counter wrap.
module tb_sync_handshake_rx;

    localparam int unsigned DW     = 32;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned CW     = 2;

    logic          OCLK = 1'b0;
    logic          RST_OCLK;
    logic          REQ_OCLK;
    logic [DW-1:0] D_IN_OCLK;
    logic          ACK_OCLK;
    logic [DW-1:0] D_OUT_OCLK;
    logic          VALID_OCLK;
    logic          RDY_OCLK;
    logic          ERR_OCLK;
    logic [CW-1:0] XFER_CNT_OCLK;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt;
    logic [DW-1:0] held;

    sync_handshake_rx #(
        .P_D_BITWIDTH  (DW),
        .P_SETTLE_CYC  (SETTLE),
        .P_CNT_BITWIDTH(CW)
    ) dut (
        .OCLK         (OCLK),
        .RST_OCLK     (RST_OCLK),
        .REQ_OCLK     (REQ_OCLK),
        .D_IN_OCLK    (D_IN_OCLK),
        .ACK_OCLK     (ACK_OCLK),
        .D_OUT_OCLK   (D_OUT_OCLK),
        .VALID_OCLK   (VALID_OCLK),
        .RDY_OCLK     (RDY_OCLK),
        .ERR_OCLK     (ERR_OCLK),
        .XFER_CNT_OCLK(XFER_CNT_OCLK)
    );

    always #5 OCLK = ~OCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge OCLK);
        #1;
    endtask

    // Consumer-side scoreboard: a word offered with ready and a live request is
    // taken at the next edge, so it must match the oldest expected word.
    always @(negedge OCLK) begin
        if (!RST_OCLK && VALID_OCLK && RDY_OCLK && REQ_OCLK) begin
            if (exp_q.size() == 0) chk("sb_unexpected_word", 64'(D_OUT_OCLK), 64'hFFFF_FFFF_FFFF_FFFF);
            else                   chk("sb_data", 64'(D_OUT_OCLK), 64'(exp_q.pop_front()));
        end
    end

    task automatic do_reset();
        RST_OCLK = 1'b1;
        REQ_OCLK = 1'b0;
        tick();
        tick();
        RST_OCLK = 1'b0;
        exp_cnt  = '0;
    endtask

    // Full four-phase transfer with ready high; checks minimum ack latency.
    task automatic full_xfer(input logic [DW-1:0] data);
        int n;
        D_IN_OCLK = data;
        REQ_OCLK  = 1'b1;
        RDY_OCLK  = 1'b1;
        exp_q.push_back(data);
        n = 0;
        while (!ACK_OCLK && n < 50) begin
            tick();
            n++;
        end
        chk("xfer_ack_seen", 64'(ACK_OCLK), 64'd1);
        chk("xfer_ack_latency", 64'(n), 64'(SETTLE + 3));
        exp_cnt = exp_cnt + 1'b1;
        chk("xfer_cnt", 64'(XFER_CNT_OCLK), 64'(exp_cnt));
        REQ_OCLK = 1'b0;
        tick();
        chk("xfer_ack_rtz", 64'(ACK_OCLK), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_OCLK  = 1'b1;
        REQ_OCLK  = 1'b0;
        RDY_OCLK  = 1'b1;
        D_IN_OCLK = '0;
        exp_cnt   = '0;

        // Reset state (edges 1..3 in reset)
        tick(); tick(); tick();
        chk("rst_ack",   64'(ACK_OCLK),      64'd0);
        chk("rst_valid", 64'(VALID_OCLK),    64'd0);
        chk("rst_dout",  64'(D_OUT_OCLK),    64'd0);
        chk("rst_err",   64'(ERR_OCLK),      64'd0);
        chk("rst_cnt",   64'(XFER_CNT_OCLK), 64'd0);
        RST_OCLK = 1'b0;

        // Basic transfer: REQ first sampled at edge 10
        for (int i = 4; i <= 9; i++) tick();
        D_IN_OCLK = 32'hDEADBEEF;
        REQ_OCLK  = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        tick(); tick(); tick();                 // edges 10..12
        chk("basic_valid_e12", 64'(VALID_OCLK), 64'd0);
        tick();                                 // edge 13
        chk("basic_valid_e13", 64'(VALID_OCLK), 64'd1);
        chk("basic_dout_e13",  64'(D_OUT_OCLK), 64'hDEADBEEF);
        chk("basic_ack_e13",   64'(ACK_OCLK),   64'd0);
        tick();                                 // edge 14
        chk("basic_ack_e14",   64'(ACK_OCLK),      64'd1);
        chk("basic_valid_e14", 64'(VALID_OCLK),    64'd0);
        chk("basic_cnt_e14",   64'(XFER_CNT_OCLK), 64'd1);
        for (int i = 15; i <= 19; i++) tick();
        chk("basic_ack_e19", 64'(ACK_OCLK), 64'd1);
        REQ_OCLK = 1'b0;
        tick();                                 // edge 20
        chk("basic_ack_e20", 64'(ACK_OCLK), 64'd0);
        exp_cnt = 1;

        // Backpressure: ready low for 5 cycles after valid rises
        RDY_OCLK  = 1'b0;
        D_IN_OCLK = 32'h12345678;
        REQ_OCLK  = 1'b1;
        exp_q.push_back(32'h12345678);
        tick(); tick(); tick(); tick();
        chk("bp_valid_rise", 64'(VALID_OCLK), 64'd1);
        held = D_OUT_OCLK;
        chk("bp_dout", 64'(held), 64'h12345678);
        D_IN_OCLK = 32'h0BAD0BAD;              // bus wiggle must not reach the output
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_hold", 64'(VALID_OCLK), 64'd1);
            chk("bp_dout_stable", 64'(D_OUT_OCLK), 64'(held));
            chk("bp_ack_low", 64'(ACK_OCLK), 64'd0);
        end
        RDY_OCLK = 1'b1;
        tick();
        chk("bp_ack_high", 64'(ACK_OCLK), 64'd1);
        chk("bp_valid_low", 64'(VALID_OCLK), 64'd0);
        chk("bp_cnt", 64'(XFER_CNT_OCLK), 64'd2);
        REQ_OCLK = 1'b0;
        tick();
        chk("bp_ack_rtz", 64'(ACK_OCLK), 64'd0);

        // Early request drop during settle
        do_reset();
        RDY_OCLK  = 1'b1;
        D_IN_OCLK = 32'hBAD00001;
        REQ_OCLK  = 1'b1;
        tick(); tick();                         // IDLE->SETTLE, one countdown
        REQ_OCLK = 1'b0;
        tick();
        chk("early_err", 64'(ERR_OCLK), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("early_valid", 64'(VALID_OCLK), 64'd0);
            chk("early_ack",   64'(ACK_OCLK),   64'd0);
            tick();
        end
        chk("early_cnt", 64'(XFER_CNT_OCLK), 64'd0);
        full_xfer(32'hCAFE0001);
        chk("early_after_cnt", 64'(XFER_CNT_OCLK), 64'd1);
        chk("early_err_sticky", 64'(ERR_OCLK), 64'd1);

        // Simultaneous REQ=0 and RDY=1 in HOLD
        do_reset();
        RDY_OCLK  = 1'b0;
        D_IN_OCLK = 32'hA5A5A5A5;
        REQ_OCLK  = 1'b1;
        tick(); tick(); tick(); tick();
        chk("sim_valid_hold", 64'(VALID_OCLK), 64'd1);
        REQ_OCLK = 1'b0;
        RDY_OCLK = 1'b1;
        tick();
        chk("sim_err",   64'(ERR_OCLK),      64'd1);
        chk("sim_valid", 64'(VALID_OCLK),    64'd0);
        chk("sim_ack",   64'(ACK_OCLK),      64'd0);
        chk("sim_cnt",   64'(XFER_CNT_OCLK), 64'd0);
        chk("sim_dout_kept", 64'(D_OUT_OCLK), 64'hA5A5A5A5);
        tick();
        chk("sim_ack_later", 64'(ACK_OCLK), 64'd0);

        // Reset while in ACK
        do_reset();
        RDY_OCLK  = 1'b1;
        D_IN_OCLK = 32'h55AA55AA;
        REQ_OCLK  = 1'b1;
        exp_q.push_back(32'h55AA55AA);
        for (int i = 0; i < SETTLE + 3; i++) tick();
        chk("rmid_in_ack", 64'(ACK_OCLK), 64'd1);
        RST_OCLK = 1'b1;
        tick();
        chk("rmid_ack",   64'(ACK_OCLK),      64'd0);
        chk("rmid_valid", 64'(VALID_OCLK),    64'd0);
        chk("rmid_dout",  64'(D_OUT_OCLK),    64'd0);
        chk("rmid_err",   64'(ERR_OCLK),      64'd0);
        chk("rmid_cnt",   64'(XFER_CNT_OCLK), 64'd0);
        tick();
        chk("rmid_ack_req_high", 64'(ACK_OCLK), 64'd0);
        RST_OCLK = 1'b0;
        REQ_OCLK = 1'b0;
        exp_cnt  = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rmid_ack_idle", 64'(ACK_OCLK), 64'd0);
        end
        full_xfer(32'h00C0FFEE);

        // Back-to-back with counter wrap: 1,2,3,0,1
        do_reset();
        for (int i = 1; i <= 5; i++) full_xfer(32'(i));
        chk("wrap_final_cnt", 64'(XFER_CNT_OCLK), 64'd1);

        tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
